// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: sends header, 8 payload bytes and an additive checksum
// as 10 back-to-back 8N1 characters on each rising edge of uart_en.
module uart_frame_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned UART_BPS  = 115200,
    parameter logic [7:0]  FRAME_HDR = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_en,
    input  logic [63:0] uart_din,
    output logic        uart_tx_busy,
    output logic        tx_done,
    output logic        uart_txd
);

    localparam int unsigned BpsCnt = CLK_FREQ / UART_BPS;
    localparam int unsigned CntW   = (BpsCnt > 1) ? $clog2(BpsCnt) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(BpsCnt - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      en_q;
    logic            primed_q;
    logic            armed_q;
    logic [63:0]     data_q, data_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      byte_q, byte_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;

    logic            req;
    logic            baud_end;
    logic [7:0]      chk;
    logic [7:0]      cur_byte;

    // armed_q only sets once a genuine low sample of uart_en has been seen after reset,
    // so a level already high at release cannot masquerade as a rising edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_q     <= 2'b00;
            primed_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            en_q     <= {en_q[0], uart_en};
            primed_q <= 1'b1;
            armed_q  <= armed_q | (primed_q & ~en_q[0]);
        end
    end

    assign req      = en_q[0] & ~en_q[1] & armed_q;
    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        chk = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk = chk + data_q[8*k +: 8];
        end
    end

    // Byte indices 1..8 map to payload bytes 0..7; the low three bits minus one wrap 8 to 7.
    always_comb begin
        cur_byte = FRAME_HDR;
        if (byte_q == 4'd9) begin
            cur_byte = chk;
        end else if (byte_q != 4'd0) begin
            cur_byte = data_q[{byte_q[2:0] - 3'd1, 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        txd_d   = txd_q;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = 3'd0;
                byte_d = 4'd0;
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (req) begin
                    data_d  = uart_din;
                    state_d = StStart;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                    txd_d   = cur_byte[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q < 4'd9) begin
                        byte_d  = byte_q + 4'd1;
                        state_d = StStart;
                        txd_d   = 1'b0;
                    end else begin
                        byte_d  = 4'd0;
                        state_d = StIdle;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 4'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = busy_q;
    assign tx_done      = (state_q == StStop) && (byte_q == 4'd9) && baud_end;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: a fast-baud instance for frame content and control scenarios,
// and a default-parameter instance for bit and frame timing.
module tb_uart_frame_tx;

    localparam int FBPS = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        f_en = 1'b0;
    logic [63:0] f_din = '0;
    logic        f_busy, f_done, f_txd;
    logic        d_en = 1'b0;
    logic [63:0] d_din = '0;
    logic        d_busy, d_done, d_txd;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];

    always #5 sys_clk = ~sys_clk;

    uart_frame_tx #(
        .CLK_FREQ (80),
        .UART_BPS (10),
        .FRAME_HDR(8'hA5)
    ) u_fast (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_en     (f_en),
        .uart_din    (f_din),
        .uart_tx_busy(f_busy),
        .tx_done     (f_done),
        .uart_txd    (f_txd)
    );

    uart_frame_tx u_dflt (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_en     (d_en),
        .uart_din    (d_din),
        .uart_tx_busy(d_busy),
        .tx_done     (d_done),
        .uart_txd    (d_txd)
    );

    always @(posedge sys_clk) if (f_done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic void push_frame(input logic [63:0] din);
        logic [7:0] s;
        s = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(din[8*k +: 8]);
            s = s + din[8*k +: 8];
        end
        exp_q.push_back(s);
    endfunction

    task automatic recv_byte(output logic [7:0] b, output bit ok, output bit to);
        int n;
        n  = 0;
        b  = '0;
        ok = 1'b1;
        to = 1'b0;
        while (f_txd !== 1'b0 && n < 40 * FBPS) begin
            @(negedge sys_clk);
            n++;
        end
        if (f_txd !== 1'b0) begin
            to = 1'b1;
            return;
        end
        repeat (FBPS / 2) @(negedge sys_clk);
        if (f_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (FBPS) @(negedge sys_clk);
            b[i] = f_txd;
        end
        repeat (FBPS) @(negedge sys_clk);
        if (f_txd !== 1'b1) ok = 1'b0;
    endtask

    task automatic recv_frame(output logic [79:0] got, output bit ok, output bit to);
        logic [7:0] b;
        bit         bok;
        got = '0;
        ok  = 1'b1;
        to  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            recv_byte(b, bok, to);
            if (to) return;
            got[8*i +: 8] = b;
            ok = ok & bok;
        end
    endtask

    task automatic wait_idle(output bit to);
        int n;
        n = 0;
        while (f_busy !== 1'b0 && n < 4 * FBPS) begin
            @(negedge sys_clk);
            n++;
        end
        to = (f_busy !== 1'b0);
    endtask

    task automatic pulse_en();
        @(negedge sys_clk);
        f_en = 1'b1;
        repeat (2) @(negedge sys_clk);
        f_en = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (f_txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", f_txd); end
        checks++;
        if (f_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", f_busy); end
        checks++;
        if (f_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", f_done); end
        checks++;
        if (d_txd !== 1'b1) begin failures++; $display("FAIL reset_dflt_txd: got %b expected 1", d_txd); end
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        logic [79:0] got;
        bit ok, to, ito;
        int d0;
        d0 = done_cnt;
        f_din = 64'h0807060504030201;
        push_frame(f_din);
        @(negedge sys_clk);
        f_en = 1'b1;
        @(posedge sys_clk); #1;
        checks++;
        if (f_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_early: got %b expected 0", f_busy); end
        @(posedge sys_clk); #1;
        checks++;
        if (f_busy !== 1'b1 || f_txd !== 1'b0)
            begin failures++; $display("FAIL basic_accept: got busy=%b txd=%b expected busy=1 txd=0", f_busy, f_txd); end
        @(negedge sys_clk);
        f_en = 1'b0;
        recv_frame(got, ok, to);
        checks++;
        if (to || !ok) begin failures++; $display("FAIL basic_framing: got to=%0d ok=%0d expected to=0 ok=1", to, ok); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL basic_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        checks++;
        if (got[79:72] !== 8'h24) begin failures++; $display("FAIL basic_chk: got %h expected 24", got[79:72]); end
        wait_idle(ito);
        checks++;
        if (ito || done_cnt - d0 != 1)
            begin failures++; $display("FAIL basic_done: got idle_to=%0d pulses=%0d expected 0 and 1", ito, done_cnt - d0); end
    endtask

    task automatic test_all_ones();
        logic [79:0] got;
        bit ok, to, ito;
        f_din = 64'hFFFF_FFFF_FFFF_FFFF;
        push_frame(f_din);
        pulse_en();
        recv_frame(got, ok, to);
        checks++;
        if (to || !ok) begin failures++; $display("FAIL ones_framing: got to=%0d ok=%0d expected to=0 ok=1", to, ok); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL ones_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        checks++;
        if (got[79:72] !== 8'hF8) begin failures++; $display("FAIL ones_chk: got %h expected f8", got[79:72]); end
        wait_idle(ito);
    endtask

    task automatic test_hold_en();
        logic [79:0] got;
        bit ok, to, ito;
        int d0, busy_cycles;
        d0 = done_cnt;
        f_din = 64'h1122_3344_5566_7788;
        push_frame(f_din);
        @(negedge sys_clk);
        f_en = 1'b1;
        fork
            recv_frame(got, ok, to);
            begin
                repeat (300) @(negedge sys_clk);
                f_en = 1'b0;
                repeat (3) @(negedge sys_clk);
                f_en = 1'b1;
            end
        join
        checks++;
        if (to || !ok) begin failures++; $display("FAIL hold_framing: got to=%0d ok=%0d expected to=0 ok=1", to, ok); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL hold_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        wait_idle(ito);
        busy_cycles = 0;
        repeat (200) begin
            @(negedge sys_clk);
            if (f_busy !== 1'b0 || f_txd !== 1'b1) busy_cycles++;
        end
        checks++;
        if (ito || busy_cycles != 0 || done_cnt - d0 != 1)
            begin failures++; $display("FAIL hold_single: got busy_cycles=%0d pulses=%0d expected 0 and 1", busy_cycles, done_cnt - d0); end
        f_en = 1'b0;
        repeat (4) @(negedge sys_clk);
        f_din = 64'hDEAD_BEEF_0BAD_F00D;
        push_frame(f_din);
        pulse_en();
        recv_frame(got, ok, to);
        checks++;
        if (to || !ok) begin failures++; $display("FAIL hold2_framing: got to=%0d ok=%0d expected to=0 ok=1", to, ok); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL hold2_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        wait_idle(ito);
    endtask

    task automatic test_back_to_back();
        logic [79:0] got;
        bit ok, to, ito;
        int n;
        f_din = 64'h0102_0304_0506_0708;
        push_frame(f_din);
        pulse_en();
        recv_frame(got, ok, to);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL b2b_a_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        n = 0;
        while (f_done !== 1'b1 && n < 4 * FBPS) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (f_done !== 1'b1) begin failures++; $display("FAIL b2b_done_seen: got %b expected 1", f_done); end
        // Edge lands so the request is detected in the cycle busy falls.
        f_din = 64'hA0B0_C0D0_E0F0_0010;
        push_frame(f_din);
        f_en = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (f_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall: got %b expected 0", f_busy); end
        @(negedge sys_clk);
        checks++;
        if (f_busy !== 1'b1 || f_txd !== 1'b0)
            begin failures++; $display("FAIL b2b_accept: got busy=%b txd=%b expected busy=1 txd=0", f_busy, f_txd); end
        f_en = 1'b0;
        recv_frame(got, ok, to);
        checks++;
        if (to || !ok) begin failures++; $display("FAIL b2b_framing: got to=%0d ok=%0d expected to=0 ok=1", to, ok); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL b2b_b_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        wait_idle(ito);
    endtask

    task automatic test_din_change();
        logic [79:0] got;
        bit ok, to, ito;
        int n;
        f_din = 64'h1357_9BDF_2468_ACE0;
        push_frame(f_din);
        @(negedge sys_clk);
        f_en = 1'b1;
        n = 0;
        while (f_busy !== 1'b1 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        f_din = 64'hFFFF_0000_FFFF_0000;
        f_en  = 1'b0;
        recv_frame(got, ok, to);
        checks++;
        if (to || !ok) begin failures++; $display("FAIL din_framing: got to=%0d ok=%0d expected to=0 ok=1", to, ok); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL din_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        wait_idle(ito);
    endtask

    task automatic test_reset_mid();
        logic [79:0] got;
        logic [7:0]  b;
        bit ok, to, ito;
        int d0, bad;
        f_din = 64'h7766_5544_3322_1100;
        push_frame(f_din);
        pulse_en();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            recv_byte(b, ok, to);
            e = exp_q.pop_front();
            checks++;
            if (to || b !== e)
                begin failures++; $display("FAIL rst_pre_byte%0d: got %h expected %h", i, b, e); end
        end
        repeat (3 * FBPS) @(negedge sys_clk);
        exp_q.delete();
        f_en = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (f_txd !== 1'b1 || f_busy !== 1'b0)
            begin failures++; $display("FAIL rst_abort: got txd=%b busy=%b expected txd=1 busy=0", f_txd, f_busy); end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge sys_clk);
            if (f_busy !== 1'b0 || f_txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_no_resume: got active_cycles=%0d expected 0", bad); end
        f_en = 1'b0;
        repeat (4) @(negedge sys_clk);
        d0 = done_cnt;
        f_din = 64'h0F1E_2D3C_4B5A_6978;
        push_frame(f_din);
        pulse_en();
        recv_frame(got, ok, to);
        checks++;
        if (to || !ok) begin failures++; $display("FAIL rst_framing: got to=%0d ok=%0d expected to=0 ok=1", to, ok); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got[8*i +: 8] !== e)
                begin failures++; $display("FAIL rst_byte%0d: got %h expected %h", i, got[8*i +: 8], e); end
        end
        wait_idle(ito);
        checks++;
        if (ito || done_cnt - d0 != 1)
            begin failures++; $display("FAIL rst_done: got idle_to=%0d pulses=%0d expected 0 and 1", ito, done_cnt - d0); end
    endtask

    task automatic test_timing();
        int n, cyc, start_len, done_at, done_hi;
        bit first;
        d_din = 64'h0;
        @(negedge sys_clk);
        d_en = 1'b1;
        n = 0;
        while (d_txd !== 1'b0 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        d_en = 1'b0;
        checks++;
        if (d_txd !== 1'b0) begin failures++; $display("FAIL tim_start: got txd=%b expected 0", d_txd); end
        cyc = 1;
        start_len = 0;
        first = 1'b1;
        done_at = 0;
        done_hi = 0;
        while (d_busy === 1'b1 && cyc < 50000) begin
            if (first && d_txd === 1'b0) start_len++;
            else first = 1'b0;
            if (d_done === 1'b1) begin
                done_hi++;
                if (done_at == 0) done_at = cyc;
            end
            @(negedge sys_clk);
            cyc++;
        end
        checks++;
        if (start_len != 434) begin failures++; $display("FAIL tim_bit: got %0d expected 434", start_len); end
        checks++;
        if (done_at != 43400) begin failures++; $display("FAIL tim_frame: got %0d expected 43400", done_at); end
        checks++;
        if (done_hi != 1) begin failures++; $display("FAIL tim_done_width: got %0d expected 1", done_hi); end
        checks++;
        if (cyc != 43401) begin failures++; $display("FAIL tim_busy_fall: got %0d expected 43401", cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_hold_en();
        test_back_to_back();
        test_din_change();
        test_reset_mid();
        test_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 115200, meaning line baud rate.
REQ-003 The block SHALL have parameter FRAME_HDR, default 8'hA5, meaning the header byte sent first in every frame.
REQ-004 The block SHALL have port sys_clk, input, 1 bit, meaning the single system clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit, meaning the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port uart_en, input, 1 bit, meaning the frame send request, rising-edge triggered.
REQ-007 The block SHALL have port uart_din, input, 64 bits, meaning the payload; byte k is uart_din[8k+7:8k].
REQ-008 The block SHALL have port uart_tx_busy, output, 1 bit, meaning a frame is in progress.
REQ-009 The block SHALL have port tx_done, output, 1 bit, meaning a one-cycle pulse at frame completion.
REQ-010 The block SHALL have port uart_txd, output, 1 bit, meaning the serial line, idle high.

Function
REQ-011 Bit period SHALL be BPS_CNT = CLK_FREQ/UART_BPS cycles (integer division); the default is 434.
REQ-012 The frame SHALL be 10 bytes in this order: FRAME_HDR, payload byte 0 through byte 7, then CHK.
REQ-013 CHK SHALL be the sum of payload bytes 0-7, modulo 256; the header is excluded.
REQ-014 Each byte SHALL be sent as 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); there is no extra gap between bytes.
REQ-015 uart_en SHALL be registered twice; a request is the cycle in which the sampled value is 1 and the previous sample is 0.
REQ-016 A request SHALL be accepted only in IDLE; requests while busy SHALL be dropped, not queued.
REQ-017 On accept, the block SHALL latch uart_din and compute CHK from the latched value; later changes to uart_din SHALL have no effect on the current frame.
REQ-018 On the cycle after accept, uart_tx_busy SHALL go to 1 and uart_txd SHALL go to 0 (start bit of the header).
REQ-019 The state machine SHALL have states IDLE, START, DATA, STOP.
REQ-020 State transitions:
- IDLE->START on accept.
- START->DATA after BPS_CNT cycles.
- DATA->STOP after 8 bit periods.
- STOP->START after BPS_CNT cycles if byte index < 9; otherwise STOP->IDLE.
REQ-021 The byte index SHALL run from 0 to 9 and SHALL clear on entering IDLE.
REQ-022 The bit counter SHALL run from 0 to 7; the baud counter SHALL run from 0 to BPS_CNT-1 and reload at each bit boundary.
REQ-023 Frame duration SHALL be exactly 100*BPS_CNT cycles (43400 at defaults), counted from the first start-bit cycle to the end of the last stop bit.
REQ-024 On the last cycle of the final stop bit's period, tx_done SHALL pulse for 1 cycle; uart_tx_busy SHALL fall on the following cycle, at the same time the state returns to IDLE.
REQ-025 A new request detected in the cycle uart_tx_busy falls, or any later cycle, SHALL be accepted.
REQ-026 uart_txd SHALL be driven from a register, with no combinational glitches.

Reset
REQ-027 While sys_rst_n=0, the following SHALL hold asynchronously: uart_txd=1, uart_tx_busy=0, tx_done=0, state=IDLE, all counters 0, latched data 0, and edge-detect registers 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with the line high; no partial frame SHALL resume after release.
REQ-029 After reset release, uart_en already high SHALL NOT count as a request until it goes low and then high again.

Verification
REQ-030 din=64'h0807060504030201, single uart_en pulse -> line bytes A5 01 02 03 04 05 06 07 08 24, then one tx_done pulse.
REQ-031 din=64'hFFFFFFFFFFFFFFFF -> payload bytes FF x8, CHK=F8; every data bit is 1 while start bits remain 0.
REQ-032 Bit timing at defaults -> each bit lasts 434 cycles; first start-bit edge to final stop-bit end is 43400 cycles; tx_done is high for exactly 1 cycle.
REQ-033 uart_en held high for the whole frame, plus an extra pulse mid-frame -> only one frame is sent; the next pulse after busy falls starts a second frame with correct bytes.
REQ-034 uart_din changed on the cycle after accept -> the frame carries the original value and its matching CHK.
REQ-035 sys_rst_n pulsed low during byte 4 -> uart_txd=1 and uart_tx_busy=0 within the same cycle; after release and a new uart_en edge, a complete, correct 10-byte frame is sent.
